fetch_stage: RTL and testbench

- Instruction-fetch stage of the SimpleRISC pipeline, directly upstream of the control unit.
- Owns the PC and a single-outstanding request/response handshake to instruction memory.
- Holds the IF/OF pipeline latch, which presents instruction, PC and the 6-bit opcode+I field consumed by the control unit.
- Handles OF-stage stalls, using a one-entry skid buffer, and taken-branch redirects, which flush and kill any in-flight fetch.

---
 rtl/simplerisc_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/if_of_latch.sv | 56 +++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - shared SimpleRISC constants and fetch FSM state type
package simplerisc_pkg;

    localparam int XLEN   = 32;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int I_BIT  = 26;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus
interface fetch_stage_if #(
    parameter int XLEN = simplerisc_pkg::XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_of_latch.sv
// rtl/if_of_latch.sv - IF/OF output register with a one-entry skid buffer
module if_of_latch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            skid_wr,
    input  logic            skid_to_out,
    input  logic            of_stall,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    logic            skid_valid;
    logic [XLEN-1:0] skid_inst;
    logic [XLEN-1:0] skid_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= 1'b0;
            inst       <= '0;
            pc         <= '0;
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= in_inst;
            pc    <= in_pc;
        end else if (skid_to_out && skid_valid) begin
            valid      <= 1'b1;
            inst       <= skid_inst;
            pc         <= skid_pc;
            skid_valid <= 1'b0;
        end else begin
            // skid_wr only happens while stalled, so the output stays put
            if (skid_wr) begin
                skid_valid <= 1'b1;
                skid_inst  <= in_inst;
                skid_pc    <= in_pc;
            end
            if (!of_stall) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - SimpleRISC instruction fetch: PC, single-outstanding imem handshake, IF/OF latch
module fetch_stage #(
    parameter int              XLEN     = simplerisc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   imem,
    input  logic            of_stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [5:0]      opcodeI_o
);

    import simplerisc_pkg::*;

    localparam logic [XLEN-1:0] RESET_ALIGNED = RESET_PC & ~XLEN'(3);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
    logic            kill, kill_nxt;
    logic [XLEN-1:0] br_aligned;
    logic            latch_free;
    logic            load, skid_wr, skid_to_out, flush;

    assign br_aligned     = br_target & ~XLEN'(3);
    assign latch_free     = !valid_o || !of_stall;
    assign imem.imem_req  = (state == REQ) && !reset;
    assign imem.imem_addr = fetch_pc;
    assign opcodeI_o      = {inst_o[OP_MSB:OP_LSB], inst_o[I_BIT]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= REQ;
            fetch_pc    <= RESET_ALIGNED;
            inflight_pc <= '0;
            kill        <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            inflight_pc <= inflight_pc_nxt;
            kill        <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        inflight_pc_nxt = inflight_pc;
        kill_nxt        = kill;
        load            = 1'b0;
        skid_wr         = 1'b0;
        skid_to_out     = 1'b0;
        flush           = br_taken;

        case (state)
            REQ: begin
                if (imem.imem_gnt) begin
                    state_nxt = WAIT;
                    if (br_taken) begin
                        kill_nxt     = 1'b1;
                        fetch_pc_nxt = br_aligned;
                    end else begin
                        inflight_pc_nxt = fetch_pc;
                        fetch_pc_nxt    = fetch_pc + XLEN'(PC_INC);
                    end
                end else if (br_taken) begin
                    fetch_pc_nxt = br_aligned;
                end
            end
            WAIT: begin
                if (br_taken) begin
                    fetch_pc_nxt = br_aligned;
                    // a response landing with the redirect is dropped outright
                    if (imem.imem_rvalid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (imem.imem_rvalid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else if (latch_free) begin
                        load      = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        skid_wr   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (br_taken) begin
                    fetch_pc_nxt = br_aligned;
                    state_nxt    = REQ;
                end else if (!of_stall) begin
                    skid_to_out = 1'b1;
                    state_nxt   = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    if_of_latch #(
        .XLEN(XLEN)
    ) u_latch (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .load       (load),
        .skid_wr    (skid_wr),
        .skid_to_out(skid_to_out),
        .of_stall   (of_stall),
        .in_inst    (imem.imem_rdata),
        .in_pc      (inflight_pc),
        .valid      (valid_o),
        .inst       (inst_o),
        .pc         (pc_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        of_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [5:0]  opcodeI_o;

    int n_vec;
    int n_err;

    exp_t        sb[$];
    logic [31:0] grants[$];

    logic        gnt_en;
    int          resp_delay;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic        pend_killed;
    logic        grant_next;
    logic [31:0] grant_addr;
    logic        grant_killed;
    logic        prev_valid;
    logic        prev_stall;

    fetch_stage_if #(.XLEN(32)) imem_bus ();

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem_bus),
        .of_stall (of_stall),
        .br_taken (br_taken),
        .br_target(br_target),
        .valid_o  (valid_o),
        .inst_o   (inst_o),
        .pc_o     (pc_o),
        .opcodeI_o(opcodeI_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'h2C00_0005;
        return {a[15:0] ^ a[31:16] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input string tag, input logic [31:0] exp_addr);
        for (int i = 0; i < 20; i++) begin
            if (grants.size() > 0) break;
            tick();
        end
        if (grants.size() > 0) check(tag, grants.pop_front(), exp_addr);
        else check({tag, "_timeout"}, 32'(grants.size()), 32'd1);
    endtask

    // memory model: grant when enabled, respond resp_delay edges after the grant
    always @(negedge clk) begin
        imem_bus.imem_rvalid = 1'b0;
        if (grant_next) begin
            pend        = 1'b1;
            pend_addr   = grant_addr;
            pend_cnt    = resp_delay;
            pend_killed = grant_killed;
        end
        if (pend) begin
            if (reset || br_taken) pend_killed = 1'b1;
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = mem_word(pend_addr);
                pend = 1'b0;
                if (!pend_killed) sb.push_back('{inst: mem_word(pend_addr), pc: pend_addr});
            end
        end
        imem_bus.imem_gnt = gnt_en;
        grant_next   = gnt_en && imem_bus.imem_req && !reset;
        grant_addr   = imem_bus.imem_addr;
        grant_killed = br_taken;
        if (grant_next) grants.push_back(imem_bus.imem_addr);
    end

    // output monitor: a fresh instruction is in the latch when it was empty or not stalled
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (valid_o && (!prev_valid || !prev_stall)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_pc", pc_o, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_inst", inst_o, e.inst);
                    check("sb_pc", pc_o, e.pc);
                    check("sb_opcodeI", {26'd0, opcodeI_o}, {26'd0, e.inst[31:27], e.inst[26]});
                end
            end
            prev_valid = valid_o;
        end
        prev_stall = of_stall;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] frz_inst;
        logic [31:0] frz_pc;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        of_stall = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        gnt_en = 1'b1;
        resp_delay = 1;
        pend = 1'b0;
        pend_addr = '0;
        pend_cnt = 0;
        pend_killed = 1'b0;
        grant_next = 1'b0;
        grant_addr = '0;
        grant_killed = 1'b0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        imem_bus.imem_gnt = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = '0;

        repeat (3) tick();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_addr", imem_bus.imem_addr, 32'h100);
        check("rst_req_after", {31'd0, imem_bus.imem_req}, 32'd1);

        // sequential fetch from RESET_PC
        wait_grant("seq_addr0", 32'h100);
        wait_grant("seq_addr1", 32'h104);
        wait_grant("seq_addr2", 32'h108);
        check("opc_inst", inst_o, 32'h2C00_0005);
        check("opc_field", {26'd0, opcodeI_o}, {26'd0, 6'b001011});

        // stall while the next response returns into the skid
        for (int i = 0; i < 20; i++) begin
            if (valid_o) break;
            tick();
        end
        check("stall_pre_valid", {31'd0, valid_o}, 32'd1);
        frz_inst = inst_o;
        frz_pc = pc_o;
        of_stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("stall_valid", {31'd0, valid_o}, 32'd1);
            check("stall_inst", inst_o, frz_inst);
            check("stall_pc", pc_o, frz_pc);
            if (k == 2) grants.delete();
        end
        check("stall_no_req", 32'(grants.size()), 32'd0);
        check("stall_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
        of_stall = 1'b0;
        tick();
        check("skid_valid", {31'd0, valid_o}, 32'd1);
        check("skid_pc", pc_o, frz_pc + 32'd4);

        // redirect while WAIT, stalled latch must still flush
        of_stall = 1'b1;
        resp_delay = 3;
        grants.delete();
        wait_grant("wait_grant", frz_pc + 32'd8);
        check("wait_pre_valid", {31'd0, valid_o}, 32'd1);
        br_taken = 1'b1;
        br_target = 32'h203;
        tick();
        br_taken = 1'b0;
        of_stall = 1'b0;
        check("br_wait_valid", {31'd0, valid_o}, 32'd0);
        resp_delay = 1;
        wait_grant("br_wait_target", 32'h200);

        // redirect coinciding with a grant
        tick();
        br_taken = 1'b1;
        br_target = 32'h400;
        grants.delete();
        tick();
        br_taken = 1'b0;
        wait_grant("br_gnt_killed", 32'h204);
        check("br_gnt_valid", {31'd0, valid_o}, 32'd0);
        wait_grant("br_gnt_target", 32'h400);

        // address wrap at the top of memory
        gnt_en = 1'b0;
        repeat (4) tick();
        br_taken = 1'b1;
        br_target = 32'hFFFF_FFFE;
        tick();
        br_taken = 1'b0;
        check("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_req", {31'd0, imem_bus.imem_req}, 32'd1);
        grants.delete();
        gnt_en = 1'b1;
        wait_grant("wrap_top", 32'hFFFF_FFFC);
        resp_delay = 3;
        wait_grant("wrap_zero", 32'h0);

        // asynchronous reset with a response still outstanding
        gnt_en = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", {31'd0, valid_o}, 32'd0);
        check("async_inst", inst_o, 32'd0);
        check("async_pc", pc_o, 32'd0);
        check("async_req", {31'd0, imem_bus.imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("restart_addr", imem_bus.imem_addr, 32'h100);
        repeat (3) tick();
        check("late_rvalid_ignored", {31'd0, valid_o}, 32'd0);
        resp_delay = 1;
        grants.delete();
        gnt_en = 1'b1;
        wait_grant("restart_grant", 32'h100);
        repeat (4) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
